branch_sequencer: RTL and testbench
===================================

# branch_sequencer

Sequential fetch/redirect controller for the project_1 processor. It owns the program counter and the architectural Z/N flag register, and evaluates branches from EX through the combinational `jump_unit`. On a taken branch it redirects fetch and squashes the wrong-path instructions still in flight. It sits between decode/EX control and the instruction-memory address port.

## Interface
Parameters:
- `PC_WIDTH`, 32, width of PC and branch target
- `PC_STEP`, 4, sequential PC increment
- `RESET_PC`, 0, PC value after reset
- `SQUASH_CYCLES`, 2, number of wrong-path instructions reaching EX after a taken branch (≥1)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `stall`  in  1  front-end hold from the hazard unit
- `halt_req`  in  1  HALT instruction in EX
- `flag_we`  in  1  ALU result in EX updates the flags
- `alu_z`, `alu_n`  in  1 each  ALU zero/negative results
- `branch_valid`  in  1  the EX instruction is a branch
- `branch_ni`, `branch_i`, `branch_b`  in  1 each  branch-if-not-zero, branch-if-zero, unconditional
- `branch_target`  in  PC_WIDTH  resolved target address
- `pc`  out  PC_WIDTH  fetch address
- `fetch_en`  out  1  instruction memory read enable
- `squash`  out  1  suppresses all EX side effects (regfile, memory, flags, branch, halt)
- `flag_z`, `flag_n`  out  1 each  registered flags
- `halted`  out  1  core halted

## Operation
- FSM states: RUN, SQUASH, HALT. Reset value: RUN.
- `taken` = branch_valid & ((branch_ni & ~flag_z) | branch_b | (branch_i & flag_z)). Branches use the registered flags only.
- RUN, priority order:
  - taken: pc ← branch_target; go to SQUASH with cnt ← SQUASH_CYCLES−1.
  - else halt_req: go to HALT; pc holds.
  - else stall: pc holds.
  - else: pc ← pc + PC_STEP, wrapping modulo 2^PC_WIDTH.
- A taken branch overrides a simultaneous `stall`.
- SQUASH:
  - `squash`=1. The inputs branch_valid, halt_req and flag_we are ignored.
  - pc advances, or holds on stall, as in RUN.
  - cnt decrements only when `stall`=0. At cnt=0 with `stall`=0, return to RUN.
- HALT:
  - `fetch_en`=0 and `halted`=1. pc and flags are frozen.
  - The only exit is `rst`.
- Flags: in RUN, when flag_we=1, flag_z ← alu_z and flag_n ← alu_n. Writes are not gated by stall.
- When flag_we and branch_valid occur in the same cycle, the branch sees the old flags.
- flag_n is stored but never affects `taken`.

## Timing
- Reset values: pc=RESET_PC, fetch_en=1, squash=0, flag_z=0, flag_n=0, halted=0.
- Reset asynchronously forces every output and state to its reset value, including in mid-SQUASH or HALT.
- Taken branch in cycle T:
  - pc=branch_target from T+1.
  - squash=1 for SQUASH_CYCLES non-stalled cycles, starting at T+1.
  - The first target-path instruction reaches EX at T+SQUASH_CYCLES+1 (no stalls).
- `squash`, `halted` and `fetch_en` are Moore outputs decoded from state, so they have no combinational path from inputs.
- `taken` reaches the pc mux combinationally but is not exported.
- A branch arriving in the first RUN cycle after SQUASH is honoured normally.

## Structure
- Package `seq_pkg`:
  - state enum `seq_state_t` {RUN, SQUASH, HALT}
  - default parameter constants
- Instantiate the existing `jump_unit` as the single sub-module. Connections: FlagZ=flag_z, FlagN=flag_n, BranchNI/BranchI/BranchB = branch_* gated by branch_valid. Its PCSource is `taken`.
- Counter width is $clog2(SQUASH_CYCLES)+1.

## Test plan
- Reset, then 3 free-running cycles -> pc 0, 4, 8, 12; fetch_en=1; squash=0.
- flag_we=1 with alu_z=1 at T0; branch_i=1, branch_valid=1, target 0x40 at T1 -> pc=0x40 at T2; squash high at T2 and T3; low at T4.
- flag_z=0 with branch_i=1 -> not taken, pc+4. flag_z=0 with branch_ni=1, target 0x100 -> taken. flag_z=1 with branch_ni=1 -> not taken.
- branch_b=1 while a new branch_valid arrives during SQUASH -> the second branch is ignored. A stall during SQUASH extends squash by exactly the stalled cycles.
- halt_req=1 in RUN at pc=0x20 -> halted=1 and fetch_en=0 next cycle; pc stays 0x20 for 10 cycles; rst -> pc=0, state RUN.
- pc=0xFFFF_FFFC with no stall -> pc wraps to 0. Asserting rst mid-SQUASH -> squash=0 immediately.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and default parameter values for the fetch/redirect sequencer.
package seq_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SQUASH = 2'd1,
    HALT   = 2'd2
  } seq_state_t;

  localparam int DEF_PC_WIDTH      = 32;
  localparam int DEF_PC_STEP       = 4;
  localparam int DEF_RESET_PC      = 0;
  localparam int DEF_SQUASH_CYCLES = 2;

endpackage

// File: rtl/jump_unit.sv
// Combinational branch decision: selects the branch target when the
// branch condition holds against the supplied flags.
module jump_unit (
  input  logic FlagZ,
  input  logic FlagN,
  input  logic BranchNI,
  input  logic BranchI,
  input  logic BranchB,
  output logic PCSource
);

  // The negative flag is part of the interface but no branch tests it.
  logic unused_flag_n;
  assign unused_flag_n = FlagN;

  // Taken when: not-zero branch with Z clear, zero branch with Z set, or unconditional.
  always_comb begin
    PCSource = (BranchNI & ~FlagZ) | BranchB | (BranchI & FlagZ);
  end

endmodule

// File: rtl/branch_sequencer.sv
// Fetch/redirect controller: owns the PC and the Z/N flags, redirects on
// taken branches and squashes the wrong-path instructions behind them.
module branch_sequencer
  import seq_pkg::*;
#(
  parameter int PC_WIDTH      = DEF_PC_WIDTH,
  parameter int PC_STEP       = DEF_PC_STEP,
  parameter int RESET_PC      = DEF_RESET_PC,
  parameter int SQUASH_CYCLES = DEF_SQUASH_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                halt_req,
  input  logic                flag_we,
  input  logic                alu_z,
  input  logic                alu_n,
  input  logic                branch_valid,
  input  logic                branch_ni,
  input  logic                branch_i,
  input  logic                branch_b,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] pc,
  output logic                fetch_en,
  output logic                squash,
  output logic                flag_z,
  output logic                flag_n,
  output logic                halted
);

  localparam int CNT_W = $clog2(SQUASH_CYCLES) + 1;
  localparam logic [CNT_W-1:0]    CNT_INIT  = CNT_W'(SQUASH_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [PC_WIDTH-1:0] PC_INC    = PC_WIDTH'(PC_STEP);
  localparam logic [PC_WIDTH-1:0] PC_RESET  = PC_WIDTH'(RESET_PC);

  seq_state_t          state;
  logic [CNT_W-1:0]    cnt;
  logic [PC_WIDTH-1:0] pc_seq;
  logic                taken;

  // Branch conditions only count when EX actually holds a branch; the
  // decision uses the registered flags, never this cycle's ALU result.
  jump_unit u_jump_unit (
    .FlagZ    (flag_z),
    .FlagN    (flag_n),
    .BranchNI (branch_ni & branch_valid),
    .BranchI  (branch_i  & branch_valid),
    .BranchB  (branch_b  & branch_valid),
    .PCSource (taken)
  );

  // Sequential next PC: hold on stall, otherwise step with natural wrap.
  always_comb begin
    if (stall) begin
      pc_seq = pc;
    end else begin
      pc_seq = pc + PC_INC;
    end
  end

  // Control FSM with PC, flags and Moore outputs all registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      cnt      <= '0;
      pc       <= PC_RESET;
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
      squash   <= 1'b0;
      halted   <= 1'b0;
      fetch_en <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          // Flag writes in RUN are independent of stall and of the branch,
          // which has already been evaluated against the old flags.
          if (flag_we) begin
            flag_z <= alu_z;
            flag_n <= alu_n;
          end
          if (taken) begin
            pc     <= branch_target;
            cnt    <= CNT_INIT;
            state  <= SQUASH;
            squash <= 1'b1;
          end else if (halt_req) begin
            state    <= HALT;
            halted   <= 1'b1;
            fetch_en <= 1'b0;
          end else begin
            pc <= pc_seq;
          end
        end
        SQUASH: begin
          // Wrong-path instructions: branch, halt and flag inputs ignored.
          pc <= pc_seq;
          if (!stall) begin
            if (cnt == '0) begin
              state  <= RUN;
              squash <= 1'b0;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
        end
        HALT: begin
          // Frozen until reset.
          state    <= HALT;
          halted   <= 1'b1;
          fetch_en <= 1'b0;
        end
        default: begin
          state    <= RUN;
          squash   <= 1'b0;
          halted   <= 1'b0;
          fetch_en <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: stimulus pushes hand-computed
// expectations, an independent monitor pops and compares after each edge.
module tb_branch_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        halt_req;
  logic        flag_we;
  logic        alu_z;
  logic        alu_n;
  logic        branch_valid;
  logic        branch_ni;
  logic        branch_i;
  logic        branch_b;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic        fetch_en;
  logic        squash;
  logic        flag_z;
  logic        flag_n;
  logic        halted;

  int total;
  int bad;

  // {pc, fetch_en, squash, flag_z, flag_n, halted}
  logic [36:0] exp_q[$];
  string       name_q[$];

  branch_sequencer #(
    .PC_WIDTH      (32),
    .PC_STEP       (4),
    .RESET_PC      (0),
    .SQUASH_CYCLES (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .halt_req      (halt_req),
    .flag_we       (flag_we),
    .alu_z         (alu_z),
    .alu_n         (alu_n),
    .branch_valid  (branch_valid),
    .branch_ni     (branch_ni),
    .branch_i      (branch_i),
    .branch_b      (branch_b),
    .branch_target (branch_target),
    .pc            (pc),
    .fetch_en      (fetch_en),
    .squash        (squash),
    .flag_z        (flag_z),
    .flag_n        (flag_n),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [36:0] pack_exp(input logic [31:0] p, input logic sq,
                                           input logic fz, input logic fn, input logic h);
    return {p, ~h, sq, fz, fn, h};
  endfunction

  function automatic logic [36:0] actual();
    return {pc, fetch_en, squash, flag_z, flag_n, halted};
  endfunction

  task automatic compare(input string nm, input logic [36:0] got, input logic [36:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got pc=%h fe=%b sq=%b z=%b n=%b h=%b, want pc=%h fe=%b sq=%b z=%b n=%b h=%b",
               nm, got[36:5], got[4], got[3], got[2], got[1], got[0],
               want[36:5], want[4], want[3], want[2], want[1], want[0]);
    end
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge.
  initial begin
    logic [36:0] e;
    string       n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        compare(n, actual(), e);
      end
    end
  end

  // Drive one cycle of inputs at the falling edge and queue the state
  // expected after the following rising edge.
  task automatic cyc(input logic s, input logic h, input logic fw, input logic az,
                     input logic an, input logic bv, input logic ni, input logic bi,
                     input logic bb, input logic [31:0] tgt,
                     input logic [31:0] epc, input logic esq, input logic efz,
                     input logic efn, input logic eh, input string nm);
    stall = s; halt_req = h; flag_we = fw; alu_z = az; alu_n = an;
    branch_valid = bv; branch_ni = ni; branch_i = bi; branch_b = bb;
    branch_target = tgt;
    exp_q.push_back(pack_exp(epc, esq, efz, efn, eh));
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall = 1'b0; halt_req = 1'b0; flag_we = 1'b0; alu_z = 1'b0; alu_n = 1'b0;
    branch_valid = 1'b0; branch_ni = 1'b0; branch_i = 1'b0; branch_b = 1'b0;
    branch_target = 32'h0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    compare("reset_state", actual(), pack_exp(32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;

    //   s  h  fw az an bv ni bi bb target         pc            sq z  n  h
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h4,        0, 0, 0, 0, "free_run_4");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h8,        0, 0, 0, 0, "free_run_8");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'hC,        0, 0, 0, 0, "free_run_c");
    cyc(0, 0, 1, 1, 1, 0, 0, 0, 0, 32'h0,         32'h10,       0, 1, 1, 0, "flag_write_z1");
    cyc(0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h40,        32'h40,       1, 1, 1, 0, "bi_taken");
    cyc(0, 1, 1, 0, 0, 1, 0, 0, 1, 32'h200,       32'h44,       1, 1, 1, 0, "squash_ignores");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h48,       0, 1, 1, 0, "squash_end");
    cyc(0, 0, 0, 0, 0, 1, 1, 0, 0, 32'h300,       32'h4C,       0, 1, 1, 0, "bni_z1_not_taken");
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,         32'h50,       0, 0, 0, 0, "flag_write_z0");
    cyc(0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h400,       32'h54,       0, 0, 0, 0, "bi_z0_not_taken");
    cyc(0, 0, 1, 1, 0, 1, 1, 0, 0, 32'h100,       32'h100,      1, 1, 0, 0, "bni_old_flags");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h100,      1, 1, 0, 0, "squash_stall_a");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h104,      1, 1, 0, 0, "squash_step_a");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h104,      1, 1, 0, 0, "squash_stall_b");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h108,      0, 1, 0, 0, "squash_ext_end");
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 1, 32'h18,        32'h18,       1, 1, 0, 0, "bb_over_stall");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h1C,       1, 1, 0, 0, "bb_squash_2");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h20,       0, 1, 0, 0, "bb_squash_end");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h20,       0, 1, 0, 0, "run_stall_hold");
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h20,       0, 1, 0, 1, "halt_enter");
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1, 0, 1, 1, 0, 0, 1, 32'h80,      32'h20,       0, 1, 0, 1, "halt_frozen");
    end

    rst = 1'b1;
    idle_inputs();
    #1;
    compare("reset_from_halt", actual(), pack_exp(32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;

    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h4,        0, 0, 0, 0, "run_after_reset");
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 1, 0, 0, 0, "bb_to_top");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'hFFFF_FFF4, 1, 0, 0, 0, "top_sq_2");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'hFFFF_FFF8, 0, 0, 0, 0, "top_sq_end");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'hFFFF_FFFC, 0, 0, 0, 0, "top_fc");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,        0, 0, 0, 0, "pc_wrap");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h4,        0, 0, 0, 0, "after_wrap");
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h80,        32'h80,       1, 0, 0, 0, "bb_before_rst");

    rst = 1'b1;
    idle_inputs();
    #1;
    compare("reset_mid_squash", actual(), pack_exp(32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h4,        0, 0, 0, 0, "run_after_rst2");

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
